// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encodings, parity modes and the
// oversampling divider calculation used by both receiver and transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_DONE      = 3'd5,
    ST_WAIT_IDLE = 3'd6
  } state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  localparam int OVERSAMPLE = 16;

  function automatic int os_div(input int clk_freq, input int baud_rate);
    int d;
    d = clk_freq / (baud_rate * OVERSAMPLE);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: one-clk tick every DIV clks, phase reset by clear_i.
module uart_baud_tick #(
  parameter int DIV = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  output logic tick_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clear_i || cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tick_o = !clear_i && (cnt_q == LAST);

endmodule

// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver: 16x oversampling, 3-sample majority per bit,
// parity/framing/break reporting, one word per data_valid pulse.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 busy,
  output logic [2:0]           state_o
);

  localparam int OS_DIV = os_div(CLK_FREQ, BAUD_RATE);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] S_LO   = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] S_MID  = TW'(OVERSAMPLE / 2);
  localparam logic [TW-1:0] S_HI   = TW'(OVERSAMPLE / 2 + 1);
  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [3:0] LAST_BIT  = 4'(DATA_BITS - 1);
  localparam logic LAST_STOP = (STOP_BITS == 2);
  localparam logic PAR_ODD   = (PARITY == PARITY_ODD);

  logic sync1_q, rx_s_q, rx_prev_q;
  logic [TW-1:0] tick_cnt_q;
  logic [1:0] smp_q;
  state_e state_q;
  logic [3:0] bit_idx_q;
  logic stop_idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic perr_q, ferr_q, zero_q;
  logic [DATA_BITS-1:0] data_out_q;
  logic valid_q, perr_o_q, ferr_o_q, brk_q, busy_q;
  logic tick, start_edge, maj, at_mid, at_end;

  uart_baud_tick #(.DIV(OS_DIV)) u_tick (
    .clk_i   (clk),
    .rst_i   (rst),
    .clear_i (start_edge),
    .tick_o  (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      sync1_q   <= rx;
      rx_s_q    <= sync1_q;
      rx_prev_q <= rx_s_q;
    end
  end

  // Only a real 1->0 transition starts a frame; a line held low never retriggers.
  assign start_edge = (state_q == ST_IDLE) && rx_prev_q && !rx_s_q;
  assign maj    = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s_q) | (smp_q[1] & rx_s_q);
  assign at_mid = tick && (tick_cnt_q == S_HI);
  assign at_end = tick && (tick_cnt_q == T_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt_q <= '0;
      smp_q      <= 2'b11;
    end else begin
      if (start_edge) tick_cnt_q <= '0;
      else if (tick)  tick_cnt_q <= tick_cnt_q + 1'b1;
      if (tick && tick_cnt_q == S_LO)  smp_q[0] <= rx_s_q;
      if (tick && tick_cnt_q == S_MID) smp_q[1] <= rx_s_q;
    end
  end

  // data_valid is a one-clk strobe; data_out and all flags are valid only with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      shift_q    <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      zero_q     <= 1'b0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      perr_o_q   <= 1'b0;
      ferr_o_q   <= 1'b0;
      brk_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      valid_q  <= 1'b0;
      perr_o_q <= 1'b0;
      ferr_o_q <= 1'b0;
      brk_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_edge) begin
            state_q <= ST_START;
            busy_q  <= 1'b1;
          end
        end
        ST_START: begin
          if (at_mid && maj) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (at_end) begin
            state_q    <= ST_DATA;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            zero_q     <= 1'b1;
          end
        end
        ST_DATA: begin
          if (at_mid) begin
            shift_q <= {maj, shift_q[DATA_BITS-1:1]};
            if (maj) zero_q <= 1'b0;
          end
          if (at_end) begin
            if (bit_idx_q == LAST_BIT)
              state_q <= (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
            else
              bit_idx_q <= bit_idx_q + 1'b1;
          end
        end
        ST_PARITY: begin
          if (at_mid) begin
            if ((^shift_q ^ maj) != PAR_ODD) perr_q <= 1'b1;
            if (maj) zero_q <= 1'b0;
          end
          if (at_end) state_q <= ST_STOP;
        end
        ST_STOP: begin
          if (at_mid) begin
            if (stop_idx_q == LAST_STOP) begin
              state_q    <= ST_DONE;
              data_out_q <= shift_q;
              valid_q    <= 1'b1;
              perr_o_q   <= perr_q;
              ferr_o_q   <= ferr_q | ~maj;
              brk_q      <= zero_q & ~maj;
            end else begin
              if (!maj) ferr_q <= 1'b1;
              if (maj)  zero_q <= 1'b0;
            end
          end
          if (at_end) stop_idx_q <= 1'b1;
        end
        ST_DONE: begin
          state_q <= ferr_o_q ? ST_WAIT_IDLE : ST_IDLE;
          busy_q  <= ferr_o_q;
        end
        ST_WAIT_IDLE: begin
          if (rx_s_q) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = valid_q;
  assign parity_err = perr_o_q;
  assign frame_err  = ferr_o_q;
  assign break_det  = brk_q;
  assign busy       = busy_q;
  assign state_o    = state_q;

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Parametrised UART receiver for the ALU command path. Supports 5–9 data bits, optional odd/even parity and 1 or 2 stop bits. Uses 16x oversampling with 3-sample majority voting, a 2-flop input synchroniser, glitch-rejecting start detection, and framing/parity/break error reporting. Sits between the rx pin and the command decoder, and delivers one word per valid-strobe.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
BAUD_RATE, 9600, line bit rate
DATA_BITS, 8, payload width; legal 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2
OVERSAMPLE, 16, oversampling ticks per bit; fixed at 16, sample points are derived from it

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
rx  input  1  serial line, asynchronous to clk, idle high
data_out  output  DATA_BITS  received word, LSB = first bit on the line
data_valid  output  1  one-clk pulse, word and error flags valid
parity_err  output  1  parity mismatch for the word in the same cycle as data_valid
frame_err  output  1  a stop bit sampled 0, same cycle as data_valid
break_det  output  1  entire frame sampled 0, same cycle as data_valid
busy  output  1  high from start-edge detect until return to IDLE

Behaviour:
- Reset is asynchronous and active-high. All outputs reset to 0, synchroniser flops reset to 1, and the FSM resets to IDLE. Reset mid-frame discards the frame; no data_valid is produced.
- Tick generator: OS_DIV = CLK_FREQ/(BAUD_RATE*16), minimum 1.
  - Tick pulses once every OS_DIV clks.
  - The tick divider and the 4-bit tick_cnt both clear on start-edge detect, so sampling phase is aligned to the edge.
- Synchroniser: rx passes through two flops to give rx_s. All decisions use rx_s.
- Sampling per bit: rx_s is captured at tick_cnt 7, 8 and 9; bit value = majority of the three. The bit period ends when tick_cnt wraps from 15 to 0.
- FSM states: IDLE, START, DATA, PARITY, STOP, DONE, WAIT_IDLE.
  - IDLE: a 1→0 transition on rx_s goes to START and sets busy. A line that is held low does not retrigger.
  - START: if the majority at tick 9 is 1, it is a glitch; go to IDLE with no output. Otherwise, at the end of the bit go to DATA with bit_idx = 0.
  - DATA: shift the majority value into bit bit_idx, LSB first. After bit DATA_BITS-1, go to PARITY if PARITY != 0, else go to STOP.
  - PARITY: compare the sampled bit with the computed parity.
    - Odd: XOR of data bits plus parity bit = 1.
    - Even: XOR of data bits plus parity bit = 0.
    - A mismatch latches the internal perr.
  - STOP: sample each stop bit; any 0 sets the internal ferr.
    - The decision is made at tick 9 of the last stop bit; it does not wait for the full bit time, which tolerates baud skew on back-to-back frames.
    - With 2 stop bits, the first stop bit runs its full 16 ticks.
  - DONE (1 clk): drive data_out, data_valid = 1, parity_err = perr, frame_err = ferr, break_det = (all data bits, parity and stop bits were 0).
    - Next state is WAIT_IDLE if ferr is set, otherwise IDLE.
  - WAIT_IDLE: hold busy until rx_s = 1, then go to IDLE. This prevents a break or frame error from re-triggering a start.
- data_valid, parity_err, frame_err and break_det are single-cycle pulses, all 0 outside DONE.
- data_out holds its value until the next DONE.
- Latency: data_valid asserts 2 (synchroniser) + 1 clks after tick 9 of the last stop bit.

Decomposition:
- Shared package uart_pkg holds:
  - state encodings (3-bit)
  - PARITY_NONE/ODD/EVEN constants
  - the OVERSAMPLE constant
  - the OS_DIV computation function
- One sub-module, uart_baud_tick, contains the OS_DIV counter, the clear input and the tick output. It is reused by the future transmitter.

Test Plan:
Bench config: CLK_FREQ = 1600000, BAUD_RATE = 100000, so OS_DIV = 1 and one bit = 16 clks.
- 8N1, send 0xA5 → one data_valid, data_out = 0xA5, all error flags 0, busy deasserts within 20 clks of the stop-bit midpoint.
- 8E1, send 0x37 with correct parity bit 1, then 0x37 with parity bit 0 → first frame parity_err = 0, second frame parity_err = 1, data_out = 0x37 both times.
- 7O2, send 0x5A (7-bit) with the second stop bit forced 0 → data_out = 0x5A, frame_err = 1; FSM stays in WAIT_IDLE until rx returns high.
- 8N1, hold rx low for 30 bit times → exactly one data_valid with data_out = 0x00, frame_err = 1, break_det = 1; no second frame until rx has been high and falls again.
- Glitch: a 4-clk low pulse on an idle line → no data_valid, busy returns low within 10 clks.
- Assert rst mid-DATA during 0xC3, release, then send 0x81 → no output for 0xC3, data_valid with 0x81. Back-to-back 0x11, 0x22, 0x33 with no idle gap → three valid pulses in order.
